sound_frame_seq: RTL and testbench

- Frame sequencer for the APU.
- Divides the system clock down to 512 Hz and walks an 8-step sequence.
- Emits single-cycle tick pulses: length counter (256 Hz), frequency sweep (128 Hz), volume envelope (64 Hz).
- Drives the length-clock input of every channel's length counter, plus the sweep and envelope units; held idle while APU master power (NR52 bit 7) is off.

---
 rtl/sound_pkg.sv | 38 +++
 rtl/sound_prescaler.sv | 56 +++++
 rtl/sound_frame_seq.sv | 67 ++++++
 tb/tb_sound_frame_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared APU sound constants and frame-sequencer step decode helpers.
// Channel trigger logic reuses the is_*_step helpers for length/sweep quirks.
package sound_pkg;

   localparam int SND_CLK_DIV_512HZ = 8192;
   localparam int SND_STEP_W        = 3;

   typedef logic [SND_STEP_W-1:0] snd_step_t;

   localparam snd_step_t SND_STEP_RESET = 3'd7;

   typedef struct packed {
      logic len;
      logic sweep;
      logic env;
   } snd_ticks_t;

   function automatic logic is_len_step(input snd_step_t s);
      return ~s[0];
   endfunction

   function automatic logic is_sweep_step(input snd_step_t s);
      return (s == 3'd2) || (s == 3'd6);
   endfunction

   function automatic logic is_env_step(input snd_step_t s);
      return (s == 3'd7);
   endfunction

   function automatic snd_ticks_t decode_ticks(input snd_step_t s);
      snd_ticks_t t;
      t.len   = is_len_step(s);
      t.sweep = is_sweep_step(s);
      t.env   = is_env_step(s);
      return t;
   endfunction

endpackage

// File: rtl/sound_prescaler.sv
// Frame-sequencer advance strobe: internal CLK_DIV divider, or a div_bit
// falling-edge detector when SOUND_FRAME_SEQ_DIV_SYNC_EN is defined.
module sound_prescaler #(
   parameter int CLK_DIV = 8192,
   parameter int CNT_W   = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic sound_on,
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
   input  logic div_bit,
`endif
   output logic adv
);

`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN

   logic prev_q, prev_d;

   // Cleared while powered off so power-on never sees a stale high.
   always_comb begin
      prev_d = sound_on ? div_bit : 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b0;
      else     prev_q <= prev_d;
   end

   assign adv = sound_on & prev_q & ~div_bit;

`else

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wrap;

   assign wrap = (cnt_q == CNT_LAST);

   // Power-off discards partial progress so the next step is a full period away.
   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!sound_on || wrap) cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign adv = sound_on & wrap;

`endif

endmodule

// File: rtl/sound_frame_seq.sv
// APU frame sequencer: 512 Hz 8-step walk emitting length/sweep/envelope ticks.
// Optional macro SOUND_FRAME_SEQ_DIV_SYNC_EN clocks steps from DIV bit falling edges.
module sound_frame_seq
   import sound_pkg::*;
#(
   parameter int CLK_DIV = SND_CLK_DIV_512HZ,
   parameter int CNT_W   = 13
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sound_on,
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
   input  logic                  div_bit,
`endif
   output logic [SND_STEP_W-1:0] step,
   output logic                  len_tick,
   output logic                  sweep_tick,
   output logic                  env_tick,
   output logic                  len_next
);

   logic       adv;
   snd_step_t  step_q, step_d;
   snd_ticks_t ticks_q, ticks_d;

   sound_prescaler #(
      .CLK_DIV (CLK_DIV),
      .CNT_W   (CNT_W)
   ) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .sound_on (sound_on),
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
      .div_bit  (div_bit),
`endif
      .adv      (adv)
   );

   // Ticks decode the step being entered so they line up with the new step value.
   always_comb begin
      step_d  = step_q;
      ticks_d = '0;
      if (!sound_on) begin
         step_d = SND_STEP_RESET;
      end else if (adv) begin
         step_d  = step_q + SND_STEP_W'(1);
         ticks_d = decode_ticks(step_d);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_q  <= SND_STEP_RESET;
         ticks_q <= '0;
      end else begin
         step_q  <= step_d;
         ticks_q <= ticks_d;
      end
   end

   assign step       = step_q;
   assign len_tick   = ticks_q.len;
   assign sweep_tick = ticks_q.sweep;
   assign env_tick   = ticks_q.env;
   assign len_next   = step_q[0];

endmodule

// File: tb/tb_sound_frame_seq.sv
// Directed bench for sound_frame_seq with a per-cycle expected-output scoreboard.
`timescale 1ns/1ps
module tb_sound_frame_seq;

   localparam int CLK_DIV = 8;
   localparam int CNT_W   = 3;

   typedef struct packed {
      logic [2:0] step;
      logic       len;
      logic       sweep;
      logic       env;
      logic       nxt;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       sound_on;
   logic [2:0] step;
   logic       len_tick, sweep_tick, env_tick, len_next;
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
   logic       div_bit = 1'b0;
`endif

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   int         m_div;
   logic [2:0] m_step;
   logic       m_len, m_sweep, m_env, m_prev;
   int         cyc_n;

   sound_frame_seq #(.CLK_DIV(CLK_DIV), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sound_on   (sound_on),
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
      .div_bit    (div_bit),
`endif
      .step       (step),
      .len_tick   (len_tick),
      .sweep_tick (sweep_tick),
      .env_tick   (env_tick),
      .len_next   (len_next)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic obs_t observed();
      return {step, len_tick, sweep_tick, env_tick, len_next};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_div = 0; m_step = 3'd7; m_prev = 1'b0;
      m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
   endtask

   // Predict the outputs after the coming edge, push, clock, then pop and compare.
   task automatic cyc();
      obs_t e;
      logic a;
      if (rst) begin
         model_reset();
      end else begin
`ifdef SOUND_FRAME_SEQ_DIV_SYNC_EN
         a      = sound_on && m_prev && !div_bit;
         m_prev = sound_on ? div_bit : 1'b0;
`else
         a     = sound_on && (m_div == CLK_DIV - 1);
         m_div = (!sound_on || a) ? 0 : m_div + 1;
`endif
         m_len = 1'b0; m_sweep = 1'b0; m_env = 1'b0;
         if (!sound_on) m_step = 3'd7;
         else if (a) begin
            m_step  = m_step + 3'd1;
            m_len   = m_step inside {3'd0, 3'd2, 3'd4, 3'd6};
            m_sweep = m_step inside {3'd2, 3'd6};
            m_env   = (m_step == 3'd7);
         end
      end
      e = {m_step, m_len, m_sweep, m_env, (m_step inside {3'd1, 3'd3, 3'd5, 3'd7})};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      cyc_n++;
      chk("seq", observed(), exp_q.pop_front());
   endtask

   initial begin
      int first_len, n_len, n_sweep, n_env, n_next, n, n_adv;
      logic [2:0] prev_step;
      rst = 1'b1; sound_on = 1'b0;
      model_reset();
      #12;
      chk("reset_vals", observed(), {3'd7, 1'b0, 1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
      rst = 1'b0;

`ifndef SOUND_FRAME_SEQ_DIV_SYNC_EN
      // First advance, one full step cycle, and wrap.
      sound_on = 1'b1; cyc_n = 0; first_len = -1;
      n_len = 0; n_sweep = 0; n_env = 0; n_next = 0;
      repeat (80) begin
         cyc();
         if (len_tick && first_len < 0) begin
            first_len = cyc_n;
            chk("first_step", step, 0);
         end
         if (cyc_n >= 8 && cyc_n < 72) begin
            n_len += int'(len_tick); n_sweep += int'(sweep_tick);
            n_env += int'(env_tick); n_next += int'(len_next);
         end
         if (cyc_n == 64) chk("step7_env", {step, env_tick}, {3'd7, 1'b1});
         if (cyc_n == 72) chk("wrap72", {step, len_tick}, {3'd0, 1'b1});
      end
      chk("first_len_cycle", first_len, 8);
      chk("len_count", n_len, 4);
      chk("sweep_count", n_sweep, 2);
      chk("env_count", n_env, 1);
      chk("len_next_cycles", n_next, 32);

      // Power off mid-step, then on again.
      sound_on = 1'b0; cyc();
      sound_on = 1'b1; cyc_n = 0;
      repeat (19) cyc();
      chk("pre_off_step", step, 1);
      sound_on = 1'b0;
      repeat (11) begin
         cyc();
         chk("off_idle", {step, len_tick, sweep_tick, env_tick}, {3'd7, 3'b000});
      end
      sound_on = 1'b1; n = 0;
      while (n < 20) begin
         cyc(); n++;
         if (len_tick) break;
      end
      chk("restart_latency", n, 8);
      chk("restart_step", step, 0);

      // Drop power while a tick is high: no new tick afterwards.
      sound_on = 1'b0; cyc();
      chk("tick_cleared", {len_tick, step}, {1'b0, 3'd7});

      // Async reset between edges at step 5.
      sound_on = 1'b1; n = 0;
      while (step != 3'd5 && n < 200) begin cyc(); n++; end
      chk("reach_step5", step, 5);
      #2 rst = 1'b1;
      #1;
      chk("async_rst", observed(), {3'd7, 1'b0, 1'b0, 1'b0, 1'b1});
      cyc(); cyc();
      rst = 1'b0; n = 0;
      while (n < 20) begin
         cyc(); n++;
         if (len_tick) break;
      end
      chk("post_rst_latency", n, 8);
      chk("post_rst_step", step, 0);
`else
      // div_bit with a 16-cycle period: one advance per falling edge.
      sound_on = 1'b1; n_adv = 0; prev_step = step;
      for (int d = 0; d <= 64; d++) begin
         div_bit = d[3];
         cyc();
         if (step != prev_step) n_adv++;
         prev_step = step;
      end
      chk("div_adv_count", n_adv, 4);
      chk("div_step", step, 3);
      // Early high-to-low drop (DIV write) gives one extra advance.
      div_bit = 1'b1; repeat (3) cyc();
      div_bit = 1'b0; cyc();
      chk("div_extra_adv", {step, len_tick}, {3'd4, 1'b1});
      // Powered off: toggling div_bit never advances.
      sound_on = 1'b0; n_len = 0;
      for (int d = 0; d < 40; d++) begin
         div_bit = d[3];
         cyc();
         n_len += int'(len_tick) + int'(sweep_tick) + int'(env_tick);
      end
      chk("div_off_ticks", n_len, 0);
      chk("div_off_step", step, 7);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
